// File: rtl/bram_pkg.sv
// Shared types and constants for the true-dual-port block RAM.
package bram_pkg;

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  localparam int unsigned ReadLatencyMin = 1;
  localparam int unsigned ReadLatencyMax = 2;

endpackage

// File: rtl/bram_tdp_if.sv
// One RAM access port: request fields from the master, qualified read data back.
interface bram_tdp_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64
);

  logic                    en;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave (input en, we, addr, din, output dout, valid);

endinterface

// File: rtl/bram_rd_pipe.sv
// Delays accepted-access strobe and read-first data; output idles at all ones.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int unsigned Latency = 1,
  parameter int unsigned Width   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  // Out-of-range latencies are clamped to the nearest legal value.
  localparam int unsigned Lat = (Latency < ReadLatencyMin) ? ReadLatencyMin :
                                (Latency > ReadLatencyMax) ? ReadLatencyMax : Latency;

  logic [Lat-1:0]   valid_q, valid_d;
  logic [Width-1:0] data_q [Lat];
  logic [Width-1:0] data_d [Lat];

  always_comb begin
    valid_d    = '0;
    valid_d[0] = acc_i;
    data_d[0]  = data_i;
    for (int unsigned i = 1; i < Lat; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Lat; i++) data_q[i] <= '1;
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < Lat; i++) data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    valid_o = valid_q[Lat-1];
    data_o  = valid_o ? data_q[Lat-1] : '1;
  end

endmodule

// File: rtl/bram_tdp.sv
// True-dual-port RAM with byte enables, read-first data and an INIT_VALUE clear sweep.
module bram_tdp
  import bram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 12,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter int unsigned           DEPTH          = 2**ADDR_WIDTH,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '1,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clr,
  output logic      busy,
  bram_tdp_if.slave a_port,
  bram_tdp_if.slave b_port
);

  localparam int unsigned            NumLanes = DATA_WIDTH / 8;
  localparam int unsigned            IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0]        LastIdx  = IdxW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]    DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  a_acc, b_acc;
  logic [IdxW-1:0]       a_idx, b_idx, wa_idx;
  logic [NumLanes-1:0]   wa_be, wb_be;
  logic [DATA_WIDTH-1:0] wa_data, a_rd, b_rd;

  // Accesses are blocked while reset is asserted so reset never disturbs memory.
  always_comb begin
    a_acc = a_port.en && !busy && !reset && ({1'b0, a_port.addr} < DepthExt);
    b_acc = b_port.en && !busy && !reset && ({1'b0, b_port.addr} < DepthExt);
    a_idx = a_port.addr[IdxW-1:0];
    b_idx = b_port.addr[IdxW-1:0];
    a_rd  = a_acc ? mem_q[a_idx] : '1;
    b_rd  = b_acc ? mem_q[b_idx] : '1;
    wb_be = b_acc ? b_port.we : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? StClear : StReady;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == LastIdx) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      StReady: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StReady;
    endcase
  end

  // The sweep borrows port A's write path; busy already blocks both ports.
  always_comb begin
    busy    = (state_q == StClear);
    wa_be   = a_acc ? a_port.we : '0;
    wa_idx  = a_idx;
    wa_data = a_port.din;
    if (busy) begin
      wa_be   = '1;
      wa_idx  = cnt_q;
      wa_data = INIT_VALUE;
    end
  end

  // Port A is written last so it wins lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (wb_be[k]) mem_q[b_idx][k*8 +: 8] <= b_port.din[k*8 +: 8];
      if (wa_be[k]) mem_q[wa_idx][k*8 +: 8] <= wa_data[k*8 +: 8];
    end
  end

  bram_rd_pipe #(
    .Latency (READ_LATENCY),
    .Width   (DATA_WIDTH)
  ) u_rd_pipe_a (
    .clk     (clk),
    .reset   (reset),
    .acc_i   (a_acc),
    .data_i  (a_rd),
    .valid_o (a_port.valid),
    .data_o  (a_port.dout)
  );

  bram_rd_pipe #(
    .Latency (READ_LATENCY),
    .Width   (DATA_WIDTH)
  ) u_rd_pipe_b (
    .clk     (clk),
    .reset   (reset),
    .acc_i   (b_acc),
    .data_i  (b_rd),
    .valid_o (b_port.valid),
    .data_o  (b_port.dout)
  );

endmodule

// File: tb/tb_bram_tdp.sv
// Directed bench: latency-1 and latency-2 instances driven with identical stimulus.
module tb_bram_tdp;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] Ones = '1;
  localparam logic [DW-1:0] PatA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [DW-1:0] PatB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [DW-1:0] Pat5 = 64'h5555_5555_5555_5555;
  localparam logic [DW-1:0] BeRes = 64'h1122_3344_0000_0000;
  localparam logic [DW-1:0] PartRes = 64'h2222_2222_1111_1111;

  logic clk = 1'b0;
  logic reset, clr, busy1, busy2;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  bram_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a1 ();
  bram_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
  bram_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a2 ();
  bram_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();

  assign a2.en = a1.en;
  assign a2.we = a1.we;
  assign a2.addr = a1.addr;
  assign a2.din = a1.din;
  assign b2.en = b1.en;
  assign b2.we = b1.we;
  assign b2.addr = b1.addr;
  assign b2.din = b1.din;

  bram_tdp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .READ_LATENCY(1)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .busy   (busy1),
    .a_port (a1),
    .b_port (b1)
  );

  bram_tdp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .READ_LATENCY(2)) u_dut_l2 (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .busy   (busy2),
    .a_port (a2),
    .b_port (b2)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a1.en = 1'b0; a1.we = '0; a1.addr = '0; a1.din = '0;
    b1.en = 1'b0; b1.we = '0; b1.addr = '0; b1.din = '0;
  endtask

  logic [AW-1:0] lat_addr [4];
  logic [DW-1:0] lat_data [4];

  initial begin
    lat_addr = '{5'd5, 5'd3, 5'd4, 5'd6};
    lat_data = '{BeRes, PatA, PartRes, Pat5};
    reset = 1'b1;
    clr   = 1'b0;
    idle();

    // Reset held one cycle, then the power-on sweep.
    tick();
    reset = 1'b0;
    chk("rst_busy", busy1, 1);
    chk("rst_a_valid", a1.valid, 0);
    chk("rst_a_dout", a1.dout, Ones);
    chk("rst_b_valid", b1.valid, 0);
    chk("rst_b_dout", b1.dout, Ones);
    chk("rst_l2_valid", a2.valid, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy1) n++;
      tick();
    end
    chk("sweep_busy_cycles", n, 16);
    chk("sweep_done", busy1, 0);

    a1.en = 1'b1; a1.addr = 5'd9;
    tick(); idle();
    chk("clr_rd_valid", a1.valid, 1);
    chk("clr_rd_data", a1.dout, Ones);

    // Out-of-range write must be dropped (addr 20 aliases index 4).
    a1.en = 1'b1; a1.addr = 5'd20; a1.we = '1; a1.din = '0;
    tick(); idle();
    chk("oor_valid", a1.valid, 0);
    chk("oor_dout", a1.dout, Ones);
    a1.en = 1'b1; a1.addr = 5'd4;
    tick(); idle();
    chk("oor_no_write", a1.dout, Ones);

    // Byte enables with read-first data.
    a1.en = 1'b1; a1.addr = 5'd5; a1.we = 8'hFF; a1.din = 64'h1122_3344_5566_7788;
    tick();
    chk("be_wr1_valid", a1.valid, 1);
    chk("be_wr1_old", a1.dout, Ones);
    a1.we = 8'h0F; a1.din = '0;
    tick();
    chk("be_wr2_old", a1.dout, 64'h1122_3344_5566_7788);
    a1.we = '0;
    tick(); idle();
    chk("be_rd", a1.dout, BeRes);

    // Same-address collisions.
    a1.en = 1'b1; a1.addr = 5'd3; a1.we = 8'hFF; a1.din = PatA;
    b1.en = 1'b1; b1.addr = 5'd3; b1.we = 8'hFF; b1.din = PatB;
    tick(); idle();
    chk("col_a_old", a1.dout, Ones);
    chk("col_b_old", b1.dout, Ones);
    b1.en = 1'b1; b1.addr = 5'd3;
    tick(); idle();
    chk("col_b_rd", b1.dout, PatA);
    a1.en = 1'b1; a1.addr = 5'd4; a1.we = 8'h0F; a1.din = 64'h1111_1111_1111_1111;
    b1.en = 1'b1; b1.addr = 5'd4; b1.we = 8'hFF; b1.din = 64'h2222_2222_2222_2222;
    tick(); idle();
    a1.en = 1'b1; a1.addr = 5'd4;
    tick(); idle();
    chk("col_partial", a1.dout, PartRes);
    a1.en = 1'b1; a1.addr = 5'd6; a1.we = 8'hFF; a1.din = Pat5;
    b1.en = 1'b1; b1.addr = 5'd6;
    tick(); idle();
    chk("xrd_old", b1.dout, Ones);
    b1.en = 1'b1; b1.addr = 5'd6;
    tick(); idle();
    chk("xrd_new", b1.dout, Pat5);

    // Four back-to-back reads on both latencies.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        a1.en = 1'b1; a1.addr = lat_addr[k];
      end else begin
        idle();
      end
      tick();
      chk($sformatf("lat1_valid_%0d", k), a1.valid, (k < 4) ? 1 : 0);
      if (k < 4) chk($sformatf("lat1_data_%0d", k), a1.dout, lat_data[k]);
      chk($sformatf("lat2_valid_%0d", k), a2.valid, (k >= 1 && k <= 4) ? 1 : 0);
      if (k >= 1 && k <= 4) chk($sformatf("lat2_data_%0d", k), a2.dout, lat_data[k-1]);
    end

    // Runtime clear with an access in the clr cycle, reads requested throughout,
    // and a second clr mid-sweep that must be ignored.
    clr = 1'b1; a1.en = 1'b1; a1.addr = 5'd5;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("drop_busy_%0d", k), busy1, (k < 16) ? 1 : 0);
      chk($sformatf("drop_v1_%0d", k), a1.valid, (k == 0 || k >= 17) ? 1 : 0);
      chk($sformatf("drop_v2_%0d", k), a2.valid, (k == 1 || k >= 18) ? 1 : 0);
      if (k == 0) chk("drop_d1_pre", a1.dout, BeRes);
      if (k == 1) chk("drop_d2_pre", a2.dout, BeRes);
      if (k == 17) chk("drop_d1_post", a1.dout, Ones);
      if (k == 18) chk("drop_d2_post", a2.dout, Ones);
      clr = (k == 5);
      tick();
    end
    clr = 1'b0;
    idle();

    // Reset at sweep address 7 restarts the sweep.
    a1.en = 1'b1; a1.addr = 5'd2; a1.we = 8'hFF; a1.din = Pat5;
    tick(); idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy_pre", busy1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", a1.valid, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy1) n++;
      tick();
    end
    chk("mid_busy_cycles", n, 16);
    chk("mid_done", busy1, 0);
    a1.en = 1'b1; a1.addr = 5'd2;
    tick(); idle();
    chk("mid_rd_cleared", a1.dout, Ones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
